// File: rtl/space_invaders_pkg.sv
// Shared constants and formation state type for the space-invaders blocks.
package space_invaders_pkg;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SPEED_Y     = 240;
    localparam int unsigned ROCKET_HALF = 2;

    typedef enum logic [0:0] {
        StMarch,
        StDone
    } form_state_t;

endpackage

// File: rtl/alien_hit_scan.sv
// Sequential rocket-vs-alien scan: tests one alien per cycle, one kill per rocket.
module alien_hit_scan
    import space_invaders_pkg::*;
#(
    parameter int unsigned COLS      = 8,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned SPACING_X = 40,
    parameter int unsigned SPACING_Y = 32,
    parameter int unsigned HALF_W    = 12,
    parameter int unsigned HALF_H    = 8,
    localparam int unsigned N        = ROWS * COLS,
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          shiprocket,
    input  logic [9:0]    shiprocketX,
    input  logic [8:0]    shiprocketY,
    input  logic [9:0]    originX,
    input  logic [8:0]    originY,
    input  logic [N-1:0]  alive,
    output logic          kill,
    output logic [IW-1:0] kill_index
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          inhibit_q, inhibit_d;
    logic [11:0]   rx, ry, cx, cy;
    logic          overlap, active;

    always_comb begin
        kill_index = IW'(32'(row_q) * COLS + 32'(col_q));
        rx = {2'b00, shiprocketX};
        ry = {3'b000, shiprocketY};
        cx = 12'(originX) + 12'(32'(col_q) * SPACING_X);
        cy = 12'(originY) + 12'(32'(row_q) * SPACING_Y);
        overlap = (rx + 12'(ROCKET_HALF) < cx + 12'(HALF_W)) &&
                  (rx + 12'(HALF_W) > cx + 12'(ROCKET_HALF)) &&
                  (ry + 12'(ROCKET_HALF) < cy + 12'(HALF_H)) &&
                  (ry + 12'(HALF_H) > cy + 12'(ROCKET_HALF));
        active = enable && shiprocket && !inhibit_q;
        kill   = active && alive[kill_index] && overlap;
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        inhibit_d = inhibit_q;
        if (!shiprocket) begin
            inhibit_d = 1'b0;
            col_d     = '0;
            row_d     = '0;
        end else if (kill || !active) begin
            // After a kill the index parks at 0 until the rocket drops.
            inhibit_d = inhibit_q || kill;
            col_d     = '0;
            row_d     = '0;
        end else if (col_q == CW'(COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end else begin
            col_d = col_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q     <= '0;
            row_q     <= '0;
            inhibit_q <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            inhibit_q <= inhibit_d;
        end
    end

endmodule

// File: rtl/alien_formation.sv
// Marching alien grid with live-bound edge reversal, descent and rocket hits.
// Optional ALIEN_SPEEDUP_EN doubles the step once a quarter or fewer remain.
module alien_formation
    import space_invaders_pkg::*;
#(
    parameter int unsigned COLS      = 8,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned START_X   = 60,
    parameter int unsigned START_Y   = 40,
    parameter int unsigned SPACING_X = 40,
    parameter int unsigned SPACING_Y = 32,
    parameter int unsigned HALF_W    = 12,
    parameter int unsigned HALF_H    = 8,
    parameter int unsigned DROP      = 16,
    parameter int unsigned LAND_Y    = 440,
    localparam int unsigned N        = ROWS * COLS,
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned RMW      = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           playing,
    input  logic           tick,
    input  logic           shiprocket,
    input  logic [9:0]     shiprocketX,
    input  logic [8:0]     shiprocketY,
    output logic [9:0]     originX,
    output logic [8:0]     originY,
    output logic [N-1:0]   alive,
    output logic [RMW-1:0] remaining,
    output logic           direction,
    output logic           alienhit,
    output logic [IW-1:0]  hit_index,
    output logic           cleared,
    output logic           landed
);

    form_state_t    state_q, state_d;
    logic [9:0]     origin_x_q, origin_x_d;
    logic [8:0]     origin_y_q, origin_y_d;
    logic [N-1:0]   alive_q, alive_d;
    logic [RMW-1:0] remaining_q, remaining_d;
    logic           direction_q, direction_d;
    logic           alienhit_q, alienhit_d;
    logic [IW-1:0]  hit_index_q, hit_index_d;
    logic           cleared_q, cleared_d;
    logic           landed_q, landed_d;

    logic           clear;
    logic           kill;
    logic [IW-1:0]  kill_index;
    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;
    logic [3:0]     lc, rc;
    logic [2:0]     br;
    logic [10:0]    left, right, bottom;
    logic [2:0]     step;
    logic           at_edge;

    assign clear = reset || !playing;

    alien_hit_scan #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .SPACING_X (SPACING_X),
        .SPACING_Y (SPACING_Y),
        .HALF_W    (HALF_W),
        .HALF_H    (HALF_H)
    ) u_scan (
        .clk         (clk),
        .reset       (clear),
        .enable      (state_q == StMarch),
        .shiprocket  (shiprocket),
        .shiprocketX (shiprocketX),
        .shiprocketY (shiprocketY),
        .originX     (origin_x_q),
        .originY     (origin_y_q),
        .alive       (alive_q),
        .kill        (kill),
        .kill_index  (kill_index)
    );

    // Bounds of the live formation; dead columns and rows do not count.
    always_comb begin
        col_any = '0;
        row_any = '0;
        lc = '0;
        rc = '0;
        br = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_q[r * COLS + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) lc = 4'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) rc = 4'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) br = 3'(r);
        end
        left   = 11'(origin_x_q) + 11'(32'(lc) * SPACING_X) - 11'(HALF_W);
        right  = 11'(origin_x_q) + 11'(32'(rc) * SPACING_X) + 11'(HALF_W);
        bottom = 11'(origin_y_q) + 11'(32'(br) * SPACING_Y);
        step   = (bottom >= 11'(SPEED_Y)) ? 3'd2 : 3'd1;
`ifdef ALIEN_SPEEDUP_EN
        if (remaining_q <= RMW'(N / 4)) step = step << 1;
`endif
        at_edge = direction_q ? (right + 11'(step) > 11'(SCREEN_W)) : (left < 11'(step));
    end

    always_comb begin
        state_d     = state_q;
        origin_x_d  = origin_x_q;
        origin_y_d  = origin_y_q;
        alive_d     = alive_q;
        remaining_d = remaining_q;
        direction_d = direction_q;
        alienhit_d  = 1'b0;
        hit_index_d = hit_index_q;
        landed_d    = landed_q;
        cleared_d   = (remaining_q == '0);
        if (state_q == StMarch) begin
            if (kill) begin
                alive_d[kill_index] = 1'b0;
                remaining_d = remaining_q - RMW'(1);
                hit_index_d = kill_index;
                alienhit_d  = 1'b1;
            end
            if (tick) begin
                if (at_edge) begin
                    direction_d = !direction_q;
                    origin_y_d  = origin_y_q + 9'(DROP);
                end else if (direction_q) begin
                    origin_x_d = origin_x_q + 10'(step);
                end else begin
                    origin_x_d = origin_x_q - 10'(step);
                end
            end
            landed_d = landed_q || (bottom + 11'(HALF_H) >= 11'(LAND_Y));
            if (remaining_d == '0 || landed_d) state_d = StDone;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= StMarch;
            origin_x_q  <= 10'(START_X);
            origin_y_q  <= 9'(START_Y);
            alive_q     <= '1;
            remaining_q <= RMW'(N);
            direction_q <= 1'b1;
            alienhit_q  <= 1'b0;
            hit_index_q <= '0;
            cleared_q   <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            origin_x_q  <= origin_x_d;
            origin_y_q  <= origin_y_d;
            alive_q     <= alive_d;
            remaining_q <= remaining_d;
            direction_q <= direction_d;
            alienhit_q  <= alienhit_d;
            hit_index_q <= hit_index_d;
            cleared_q   <= cleared_d;
            landed_q    <= landed_d;
        end
    end

    assign originX   = origin_x_q;
    assign originY   = origin_y_q;
    assign alive     = alive_q;
    assign remaining = remaining_q;
    assign direction = direction_q;
    assign alienhit  = alienhit_q;
    assign hit_index = hit_index_q;
    assign cleared   = cleared_q;
    assign landed    = landed_q;

endmodule

// File: tb/tb_alien_formation.sv
// Directed bench for alien_formation with default parameters (8x4 grid).
module tb_alien_formation;

    logic        clk = 1'b0;
    logic        reset, playing, tick, shiprocket;
    logic [9:0]  shiprocketX;
    logic [8:0]  shiprocketY;
    logic [9:0]  originX;
    logic [8:0]  originY;
    logic [31:0] alive;
    logic [5:0]  remaining;
    logic        direction, alienhit, cleared, landed;
    logic [4:0]  hit_index;

    int tests = 0;
    int fails = 0;

    alien_formation dut (
        .clk         (clk),
        .reset       (reset),
        .playing     (playing),
        .tick        (tick),
        .shiprocket  (shiprocket),
        .shiprocketX (shiprocketX),
        .shiprocketY (shiprocketY),
        .originX     (originX),
        .originY     (originY),
        .alive       (alive),
        .remaining   (remaining),
        .direction   (direction),
        .alienhit    (alienhit),
        .hit_index   (hit_index),
        .cleared     (cleared),
        .landed      (landed)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic tick;
        logic rocket;
        int   rx;
        int   ry;
        int   ex;
        int   ey;
        logic edir;
        logic ehit;
        int   eidx;
        int   erem;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick = 1'b0;
        shiprocket = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Raise the rocket on an alien centre and expect a kill after idx+1 cycles.
    task automatic fire(input int x, input int y, input int idx);
        int n;
        shiprocket  = 1'b1;
        shiprocketX = 10'(x);
        shiprocketY = 9'(y);
        n = 0;
        do begin
            step();
            n++;
        end while (!alienhit && n < 40);
        chk($sformatf("fire%0d_hit", idx), 32'(alienhit), 1);
        chk($sformatf("fire%0d_latency", idx), n, idx + 1);
        chk($sformatf("fire%0d_index", idx), 32'(hit_index), idx);
        chk($sformatf("fire%0d_alivebit", idx), 32'(alive[idx]), 0);
        shiprocket = 1'b0;
        step();
    endtask

    initial begin
        int n;
        int x0, y0;
        reset = 1'b1;
        playing = 1'b1;
        tick = 1'b0;
        shiprocket = 1'b0;
        shiprocketX = '0;
        shiprocketY = '0;
        step();
        step();
        chk("rst_x", 32'(originX), 60);
        chk("rst_y", 32'(originY), 40);
        chk("rst_alive", alive, 32'hFFFF_FFFF);
        chk("rst_rem", 32'(remaining), 32);
        chk("rst_dir", 32'(direction), 1);
        chk("rst_hit", 32'(alienhit), 0);
        chk("rst_idx", 32'(hit_index), 0);
        chk("rst_cleared", 32'(cleared), 0);
        chk("rst_landed", 32'(landed), 0);
        reset = 1'b0;

        // tick rocket rx ry | x y dir hit idx rem
        vecs[0]  = '{0, 0,   0,   0, 60, 40, 1, 0, 0, 32};
        vecs[1]  = '{1, 0,   0,   0, 61, 40, 1, 0, 0, 32};
        vecs[2]  = '{1, 0,   0,   0, 62, 40, 1, 0, 0, 32};
        vecs[3]  = '{0, 0,   0,   0, 62, 40, 1, 0, 0, 32};
        vecs[4]  = '{0, 1,  62,  40, 62, 40, 1, 1, 0, 31};
        vecs[5]  = '{1, 1,  62,  40, 63, 40, 1, 0, 0, 31};
        vecs[6]  = '{0, 1,  62,  40, 63, 40, 1, 0, 0, 31};
        vecs[7]  = '{1, 0,   0,   0, 64, 40, 1, 0, 0, 31};
        vecs[8]  = '{0, 1, 104,  40, 64, 40, 1, 0, 0, 31};
        vecs[9]  = '{0, 1, 104,  40, 64, 40, 1, 1, 1, 30};
        vecs[10] = '{1, 0,   0,   0, 65, 40, 1, 0, 1, 30};
        vecs[11] = '{1, 1, 300, 300, 66, 40, 1, 0, 1, 30};
        for (int i = 0; i < 12; i++) begin
            tick = vecs[i].tick;
            shiprocket = vecs[i].rocket;
            shiprocketX = 10'(vecs[i].rx);
            shiprocketY = 9'(vecs[i].ry);
            step();
            chk($sformatf("vec%0d_x", i), 32'(originX), vecs[i].ex);
            chk($sformatf("vec%0d_y", i), 32'(originY), vecs[i].ey);
            chk($sformatf("vec%0d_dir", i), 32'(direction), 32'(vecs[i].edir));
            chk($sformatf("vec%0d_hit", i), 32'(alienhit), 32'(vecs[i].ehit));
            chk($sformatf("vec%0d_idx", i), 32'(hit_index), vecs[i].eidx);
            chk($sformatf("vec%0d_rem", i), 32'(remaining), vecs[i].erem);
        end
        tick = 1'b0;
        shiprocket = 1'b0;

        // Reset coinciding with a would-be hit: reset wins.
        do_reset();
        shiprocket = 1'b1;
        shiprocketX = 10'd60;
        shiprocketY = 9'd40;
        reset = 1'b1;
        step();
        chk("rsthit_pulse", 32'(alienhit), 0);
        chk("rsthit_rem", 32'(remaining), 32);
        reset = 1'b0;
        step();
        chk("rsthit_after_pulse", 32'(alienhit), 1);
        chk("rsthit_after_rem", 32'(remaining), 31);
        shiprocket = 1'b0;

        // March right to first reversal, then on to speed-up and landing.
        do_reset();
        tick = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("march10_x", 32'(originX), 70);
        chk("march10_y", 32'(originY), 40);
        n = 10;
        while (direction && n < 400) begin
            step();
            n++;
        end
        chk("rev1_ticks", n, 289);
        chk("rev1_x", 32'(originX), 348);
        chk("rev1_y", 32'(originY), 56);
        chk("rev1_dir", 32'(direction), 0);
        n = 0;
        while (originY < 9'd152 && n < 5000) begin
            step();
            n++;
        end
        x0 = int'(originX);
        y0 = int'(originY);
        step();
        chk("fast_y", 32'(originY), 32'(y0));
        chk("fast_dx", (x0 > int'(originX)) ? x0 - int'(originX) : int'(originX) - x0, 2);
        n = 0;
        while (!landed && n < 5000) begin
            step();
            n++;
        end
        chk("landed", 32'(landed), 1);
        chk("landed_y", 32'(originY), 344);
        x0 = int'(originX);
        for (int i = 0; i < 3; i++) step();
        chk("landed_frozen_x", 32'(originX), 32'(x0));
        chk("landed_frozen_y", 32'(originY), 344);
        tick = 1'b0;

        // Kill columns 7 and 0: reversals follow the live columns only.
        do_reset();
        for (int r = 0; r < 4; r++) fire(340, 40 + 32 * r, 7 + 8 * r);
        for (int r = 0; r < 4; r++) fire(60, 40 + 32 * r, 8 * r);
        chk("cols_rem", 32'(remaining), 24);
        tick = 1'b1;
        n = 0;
        while (direction && n < 600) begin
            step();
            n++;
        end
        chk("cols_rev_ticks", n, 329);
        chk("cols_rev_x", 32'(originX), 388);
        n = 0;
        while (originX > 10'd5 && n < 500) begin
            step();
            n++;
        end
        chk("cols_left_x", 32'(originX), 5);
        chk("cols_left_dir", 32'(direction), 0);
        chk("cols_left_y", 32'(originY), 56);
        tick = 1'b0;

        // Kill all 32, then freeze, then drop playing.
        do_reset();
        for (int k = 0; k < 32; k++) fire(60 + 40 * (k % 8), 40 + 32 * (k / 8), k);
        chk("clr_rem", 32'(remaining), 0);
        chk("clr_alive", alive, 0);
        chk("clr_cleared", 32'(cleared), 1);
        tick = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("clr_frozen_x", 32'(originX), 60);
        tick = 1'b0;
        playing = 1'b0;
        step();
        chk("noplay_x", 32'(originX), 60);
        chk("noplay_y", 32'(originY), 40);
        chk("noplay_alive", alive, 32'hFFFF_FFFF);
        chk("noplay_rem", 32'(remaining), 32);
        chk("noplay_cleared", 32'(cleared), 0);
        chk("noplay_dir", 32'(direction), 1);
        playing = 1'b1;
        tick = 1'b1;
        step();
        chk("replay_x", 32'(originX), 61);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
